// File: rtl/fb_arbiter_if.sv
// Bundle of scan, host and framebuffer-RAM signals shared by fb_arbiter and its neighbours.
// The slave modport is the arbiter's view; master is the view of the surrounding logic.
interface fb_arbiter_if #(
    parameter int DATA_WIDTH     = 48,
    parameter int PIX_ADDR_WIDTH = 11,
    parameter int BANK_WIDTH     = 4
) ();
    logic                                scan_req;
    logic [PIX_ADDR_WIDTH-1:0]           scan_addr;
    logic                                scan_gnt;
    logic                                scan_valid;
    logic [DATA_WIDTH-1:0]               scan_data;
    logic                                frame_done;
    logic                                host_valid;
    logic                                host_ready;
    logic [BANK_WIDTH-1:0]               host_bank;
    logic [PIX_ADDR_WIDTH-1:0]           host_addr;
    logic [DATA_WIDTH-1:0]               host_data;
    logic                                host_commit;
    logic                                auto_adv;
    logic                                host_err;
    logic [BANK_WIDTH-1:0]               disp_bank;
    logic [BANK_WIDTH+PIX_ADDR_WIDTH-1:0] ram_addr;
    logic                                ram_we;
    logic [DATA_WIDTH-1:0]               ram_wdata;
    logic [DATA_WIDTH-1:0]               ram_rdata;

    modport slave (
        input  scan_req, scan_addr, frame_done, host_valid, host_bank, host_addr,
               host_data, host_commit, auto_adv, ram_rdata,
        output scan_gnt, scan_valid, scan_data, host_ready, host_err, disp_bank,
               ram_addr, ram_we, ram_wdata
    );

    modport master (
        output scan_req, scan_addr, frame_done, host_valid, host_bank, host_addr,
               host_data, host_commit, auto_adv, ram_rdata,
        input  scan_gnt, scan_valid, scan_data, host_ready, host_err, disp_bank,
               ram_addr, ram_we, ram_wdata
    );
endinterface

// File: rtl/fb_arbiter.sv
// Single-port framebuffer arbiter: scan reads have priority, host writes get a starvation slot,
// and the displayed bank only changes on frame boundaries (commit or slideshow auto-advance).
module fb_arbiter #(
    parameter int DATA_WIDTH      = 48,
    parameter int PIX_ADDR_WIDTH  = 11,
    parameter int BANK_WIDTH      = 4,
    parameter int NUM_BANKS       = 12,
    parameter int FRAMES_PER_BANK = 6,
    parameter int STARVE_MAX      = 3
) (
    input  logic         clk_in,
    input  logic         rst_n,
    fb_arbiter_if.slave  bus
);
    localparam int FC_WIDTH = (FRAMES_PER_BANK > 1) ? $clog2(FRAMES_PER_BANK) : 1;
    localparam logic [1:0]            STARVE_LIM = 2'(STARVE_MAX);
    localparam logic [FC_WIDTH-1:0]   LAST_FRAME = FC_WIDTH'(FRAMES_PER_BANK - 1);
    localparam logic [BANK_WIDTH-1:0] LAST_BANK  = BANK_WIDTH'(NUM_BANKS - 1);
    localparam logic [BANK_WIDTH-1:0] BANK_LIMIT = BANK_WIDTH'(NUM_BANKS);

    typedef enum logic [1:0] {
        GNT_IDLE,
        GNT_SCAN,
        GNT_HOST
    } grant_e;

    grant_e                grant;
    logic [1:0]            starve_q, starve_d;
    logic                  scan_valid_q, scan_valid_d;
    logic                  host_err_q, host_err_d;
    logic [BANK_WIDTH-1:0] disp_bank_q, disp_bank_d;
    logic [BANK_WIDTH-1:0] pend_bank_q, pend_bank_d;
    logic                  pend_valid_q, pend_valid_d;
    logic [FC_WIDTH-1:0]   frame_cnt_q, frame_cnt_d;
    logic                  host_bank_ok;

    assign host_bank_ok = (bus.host_bank < BANK_LIMIT);

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            starve_q     <= '0;
            scan_valid_q <= 1'b0;
            host_err_q   <= 1'b0;
            disp_bank_q  <= '0;
            pend_bank_q  <= '0;
            pend_valid_q <= 1'b0;
            frame_cnt_q  <= '0;
        end else begin
            starve_q     <= starve_d;
            scan_valid_q <= scan_valid_d;
            host_err_q   <= host_err_d;
            disp_bank_q  <= disp_bank_d;
            pend_bank_q  <= pend_bank_d;
            pend_valid_q <= pend_valid_d;
            frame_cnt_q  <= frame_cnt_d;
        end
    end

    // Grants are gated by rst_n so nothing reaches the RAM while reset is held.
    always_comb begin
        grant = GNT_IDLE;
        if (rst_n) begin
            if (bus.scan_req && (starve_q < STARVE_LIM)) begin
                grant = GNT_SCAN;
            end else if (bus.host_valid) begin
                grant = GNT_HOST;
            end
        end
    end

    always_comb begin
        bus.scan_gnt   = (grant == GNT_SCAN);
        bus.host_ready = (grant == GNT_HOST);
        bus.ram_we     = (grant == GNT_HOST) && host_bank_ok;
        bus.ram_addr   = {disp_bank_q, bus.scan_addr};
        if (grant == GNT_HOST) begin
            bus.ram_addr = {bus.host_bank, bus.host_addr};
        end
        bus.ram_wdata  = bus.host_data;
        bus.scan_valid = scan_valid_q;
        bus.scan_data  = scan_valid_q ? bus.ram_rdata : '0;
        bus.disp_bank  = disp_bank_q;
        bus.host_err   = host_err_q;
    end

    always_comb begin
        starve_d     = starve_q;
        scan_valid_d = (grant == GNT_SCAN);
        host_err_d   = ((grant == GNT_HOST) || bus.host_commit) && !host_bank_ok;
        if (!bus.host_valid || (grant == GNT_HOST)) begin
            starve_d = '0;
        end else if (bus.scan_req && (starve_q < STARVE_LIM)) begin
            starve_d = starve_q + 2'd1;
        end
    end

    // Frame-boundary bank scheduling: same-cycle commit, then pending commit, then slideshow.
    always_comb begin
        disp_bank_d  = disp_bank_q;
        pend_bank_d  = pend_bank_q;
        pend_valid_d = pend_valid_q;
        frame_cnt_d  = frame_cnt_q;
        if (bus.frame_done) begin
            if (bus.host_commit && host_bank_ok) begin
                disp_bank_d  = bus.host_bank;
                pend_valid_d = 1'b0;
                frame_cnt_d  = '0;
            end else if (pend_valid_q) begin
                disp_bank_d  = pend_bank_q;
                pend_valid_d = 1'b0;
                frame_cnt_d  = '0;
            end else if (bus.auto_adv) begin
                if (frame_cnt_q == LAST_FRAME) begin
                    frame_cnt_d = '0;
                    disp_bank_d = (disp_bank_q == LAST_BANK) ? '0 : disp_bank_q + 1'b1;
                end else begin
                    frame_cnt_d = frame_cnt_q + 1'b1;
                end
            end
        end else if (bus.host_commit && host_bank_ok) begin
            pend_bank_d  = bus.host_bank;
            pend_valid_d = 1'b1;
        end
    end
endmodule

// File: doc/fb_arbiter.md
# fb_arbiter

Single-port framebuffer arbiter and bank scheduler for the LED panel path. It shares one 48-bit-wide framebuffer RAM between two requesters: the panel scan engine, which reads pixels and has priority, and a host write port, which has a starvation guard. It also owns the displayed photo bank (upper RAM address bits), switching banks only at frame boundaries, either by auto-advance (slideshow) or by an explicit host commit. It sits between the scan controller, the host upload logic and the framebuffer RAM.

## Interface
- data_width, 48, RAM word (upper+lower pixel, 8 bpp x 6)
- pix_addr_width, 11, pixel address width within a bank
- bank_width, 4, bank index width; RAM address = {bank, pixel}
- num_banks, 12, valid banks 0..num_banks-1
- frames_per_bank, 6, frame_done pulses per bank in auto mode
- starve_max, 3, consecutive host-blocked cycles before a forced host slot

Ports:
- clk_in  in  1  sole clock; all logic on posedge
- rst_n  in  1  asynchronous, active-low reset
- scan_req  in  1  scan engine requests a read
- scan_addr  in  11  pixel address within the displayed bank
- scan_gnt  out  1  read granted this cycle (combinational)
- scan_valid  out  1  scan_data valid (registered)
- scan_data  out  48  read data
- frame_done  in  1  one-cycle pulse at end of a full PWM frame
- host_valid  in  1  host write request
- host_ready  out  1  write accepted when host_valid && host_ready (combinational)
- host_bank  in  4  write/commit bank
- host_addr  in  11  write pixel address
- host_data  in  48  write data
- host_commit  in  1  pulse: display host_bank from the next frame boundary
- auto_adv  in  1  level: slideshow mode enabled
- host_err  out  1  one-cycle pulse: bank index out of range
- disp_bank  out  4  bank currently displayed
- ram_addr  out  15  RAM address (combinational)
- ram_we  out  1  RAM write enable (combinational)
- ram_wdata  out  48  RAM write data
- ram_rdata  in  48  RAM read data, registered, 1-cycle latency

## Operation
- Per-cycle grant states: IDLE (no grant), SCAN, HOST. Only one grant per cycle.
  - scan_req=1 and starve_cnt<starve_max: SCAN.
  - host_valid=1 and (scan_req=0 or starve_cnt==starve_max): HOST.
  - Otherwise: IDLE.
- SCAN: ram_addr={disp_bank, scan_addr}, ram_we=0, scan_gnt=1. The scan engine holds scan_req and scan_addr until it sees scan_gnt.
- HOST: ram_addr={host_bank, host_addr}, ram_we=1, ram_wdata=host_data, host_ready=1.
- Host writes to host_bank>=num_banks: host_ready=1 (the write is consumed), ram_we=0, host_err pulses the next cycle.
- Host writes to the displayed bank are permitted (no tearing protection).
- starve_cnt, 2 bits: increments when host_valid && scan_req && not HOST. It clears on a HOST grant or when host_valid=0, and saturates at starve_max.
- Bank scheduling on a frame_done cycle, in priority order:
  1. A host_commit in the same cycle with a valid bank: new disp_bank = that bank.
  2. Else a pending commit: disp_bank = pending bank, then clear pending.
  3. Else if auto_adv=1: frame_cnt increments. At frames_per_bank-1 it wraps to 0 and disp_bank advances, with num_banks-1 going to 0.
- On any bank change, frame_cnt clears.
- A host_commit without frame_done latches the pending bank; a later commit overwrites it.
- A commit with an invalid bank is ignored and pulses host_err.
- auto_adv=0 freezes frame_cnt.

## Timing
- Reset values (asynchronous, rst_n low): scan_valid=0, scan_data=0, disp_bank=0, host_err=0, pending cleared, frame_cnt=0, starve_cnt=0.
- Combinational grants are forced 0 while rst_n is low: scan_gnt=0, host_ready=0, ram_we=0.
- Read latency: grant in cycle N gives scan_valid=1 and scan_data=ram_rdata in cycle N+1. Back-to-back grants give one result per cycle.
- A scan read granted in the same cycle as a bank-changing frame_done uses the old bank. The new disp_bank is visible from cycle N+1.
- Worst-case scan stall is one cycle per starve_max+1 cycles under continuous host traffic.
- Deasserting rst_n mid-operation: no completion is owed; the in-flight scan_valid is dropped.

## Test plan
- Continuous scan_req, host idle: scan_gnt=1 every cycle. scan_valid follows one cycle later with ram_rdata. ram_addr[14:11]=0.
- scan_req held at 1 with host_valid=1, starve_max=3: grants repeat SCAN,SCAN,SCAN,HOST. The write appears with ram_we=1 at {host_bank, host_addr}.
- auto_adv=1, 6 frame_done pulses per step: disp_bank steps 0→1→…→11→0. With auto_adv=0 it holds.
- host_commit with bank 7 mid-frame: disp_bank stays until the next frame_done, then becomes 7. A commit in the same cycle as frame_done applies immediately and beats auto-advance.
- host_commit with bank 13, and a write with host_bank 12: each gives a host_err pulse. disp_bank is unchanged and ram_we=0.
- rst_n asserted low during a granted read: scan_valid=0 and disp_bank=0 immediately. After release, arbitration resumes in IDLE.
